// File: rtl/uart_tx_sched.sv
// uart_tx_sched -- two-port frame scheduler in front of a byte-wide UART
// transmitter.
//
// A granted port has its command byte and payload latched. The block then
// sends a five-byte frame: HDR, cmd, data[15:8], data[7:0], chk, where
// chk = ~(cmd + data[15:8] + data[7:0]) mod 256. When both ports request at
// the same time, the port that was not granted last wins.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   req0/1    in   frame request level, held by the requester until its gnt
//   cmd0/1    in   8-bit command byte of each port
//   data0/1   in   16-bit payload of each port
//   gnt0/1    out  one-cycle pulse: request accepted, operands latched
//   busy      out  high while a frame is in progress (state not IDLE)
//   frm_done  out  one-cycle pulse after the last byte of a frame completes
//   trmt      out  one-cycle byte-start strobe to the UART
//   tx_data   out  byte for the UART, held from trmt until that byte is done
//   tx_done   in   UART byte-complete level; only its rising edge is used
module uart_tx_sched #(
  parameter logic [7:0] HDR = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [7:0]  cmd0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [7:0]  cmd1,
  input  logic [15:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        frm_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [2:0]  idx_r, idx_nxt_s;
  logic [7:0]  cmd_r, cmd_nxt_s;
  logic [15:0] data_r, data_nxt_s;
  logic        prefer1_r, prefer1_nxt_s;
  logic        tx_done_q_r;
  logic        gnt0_r, gnt1_r, busy_r, frm_done_r, trmt_r;
  logic [7:0]  tx_data_r, tx_data_nxt_s;
  logic        gnt0_nxt_s, gnt1_nxt_s, frm_done_nxt_s, trmt_nxt_s;
  logic        done_edge_s;
  logic        pick1_s;

  // Ones-complement of the 8-bit wrapping sum of the three operand bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [15:0] data);
    logic [7:0] sum;
    sum = cmd + data[15:8] + data[7:0];
    return ~sum;
  endfunction

  // Byte sent at frame position idx.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] cmd,
                                            input logic [15:0] data);
    logic [7:0] b;
    case (idx)
      3'd0:    b = HDR;
      3'd1:    b = cmd;
      3'd2:    b = data[15:8];
      3'd3:    b = data[7:0];
      default: b = frame_chk(cmd, data);
    endcase
    return b;
  endfunction

  // tx_done can stay high after the previous byte, so only a fresh 0->1 counts.
  assign done_edge_s = tx_done & ~tx_done_q_r;
  // Port 1 wins when it is the only requester, or on a tie when it is favoured.
  assign pick1_s     = req1 & (~req0 | prefer1_r);

  assign gnt0     = gnt0_r;
  assign gnt1     = gnt1_r;
  assign busy     = busy_r;
  assign frm_done = frm_done_r;
  assign trmt     = trmt_r;
  assign tx_data  = tx_data_r;

  // State register, latched operands and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= 3'd0;
      cmd_r       <= 8'h00;
      data_r      <= 16'h0000;
      prefer1_r   <= 1'b0;
      tx_done_q_r <= 1'b0;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      busy_r      <= 1'b0;
      frm_done_r  <= 1'b0;
      trmt_r      <= 1'b0;
      tx_data_r   <= 8'h00;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      cmd_r       <= cmd_nxt_s;
      data_r      <= data_nxt_s;
      prefer1_r   <= prefer1_nxt_s;
      tx_done_q_r <= tx_done;
      gnt0_r      <= gnt0_nxt_s;
      gnt1_r      <= gnt1_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
      frm_done_r  <= frm_done_nxt_s;
      trmt_r      <= trmt_nxt_s;
      tx_data_r   <= tx_data_nxt_s;
    end
  end

  // Next-state logic: SEND is the single cycle that carries the next trmt.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (done_edge_s) begin
          if (idx_r == 3'd4) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = SEND;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      SEND:    state_nxt_s = WAIT;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output/datapath logic: next values of the registered outputs and operands.
  always_comb begin
    gnt0_nxt_s     = 1'b0;
    gnt1_nxt_s     = 1'b0;
    trmt_nxt_s     = 1'b0;
    frm_done_nxt_s = 1'b0;
    tx_data_nxt_s  = tx_data_r;
    idx_nxt_s      = idx_r;
    cmd_nxt_s      = cmd_r;
    data_nxt_s     = data_r;
    prefer1_nxt_s  = prefer1_r;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          trmt_nxt_s    = 1'b1;
          tx_data_nxt_s = HDR;
          idx_nxt_s     = 3'd0;
          if (pick1_s) begin
            gnt1_nxt_s    = 1'b1;
            cmd_nxt_s     = cmd1;
            data_nxt_s    = data1;
            prefer1_nxt_s = 1'b0;
          end else begin
            gnt0_nxt_s    = 1'b1;
            cmd_nxt_s     = cmd0;
            data_nxt_s    = data0;
            prefer1_nxt_s = 1'b1;
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      WAIT: begin
        if (done_edge_s) begin
          if (idx_r == 3'd4) begin
            frm_done_nxt_s = 1'b1;
            idx_nxt_s      = 3'd0;
          end else begin
            idx_nxt_s     = idx_r + 3'd1;
            trmt_nxt_s    = 1'b1;
            tx_data_nxt_s = frame_byte(idx_r + 3'd1, cmd_r, data_r);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      SEND:    idx_nxt_s = idx_r;
      default: idx_nxt_s = 3'd0;
    endcase
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter: HDR, 8'hA5, frame header byte.
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req0  input  1  port-0 (command response) frame request, level, held until gnt0.
REQ-005 SHALL have port: cmd0  input  8  port-0 command byte.
REQ-006 SHALL have port: data0  input  16  port-0 payload.
REQ-007 SHALL have port: req1  input  1  port-1 (telemetry) frame request, level, held until gnt1.
REQ-008 SHALL have port: cmd1  input  8  port-1 command byte.
REQ-009 SHALL have port: data1  input  16  port-1 payload.
REQ-010 SHALL have port: gnt0, gnt1  output  1 each  one-cycle pulse; request accepted and operands latched.
REQ-011 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port: frm_done  output  1  one-cycle pulse after the last byte of a frame completes.
REQ-013 SHALL have port: trmt  output  1  one-cycle byte-start strobe to the UART transmitter.
REQ-014 SHALL have port: tx_data  output  8  byte to the UART transmitter, stable from trmt until that byte's tx_done.
REQ-015 SHALL have port: tx_done  input  1  UART byte-complete level; it may still be high from the previous byte when trmt is asserted.

Function
REQ-016 SHALL transmit 5-byte frames in order: HDR, cmd, data[15:8], data[7:0], chk.
REQ-017 SHALL compute chk = ~(cmd + data[15:8] + data[7:0]) mod 256, from latched operands.
REQ-018 SHALL implement states IDLE, SEND, WAIT and a 3-bit byte index 0..4.
REQ-019 SHALL, IDLE with any req high at cycle N: at N+1 pulse the winning gnt, latch its cmd/data, assert trmt with tx_data=HDR, index=0, enter WAIT.
REQ-020 SHALL arbitrate round-robin: if both req high, grant the port not granted last; after reset port 0 wins a tie; a sole requester always wins.
REQ-021 SHALL detect byte completion only as a tx_done rising edge (tx_done=1, registered previous value=0); a level high carried over from the prior byte SHALL NOT count.
REQ-022 SHALL, WAIT with edge detected at cycle M and index<4: at M+1 increment index, assert trmt with the next byte (SEND state is that one cycle), return to WAIT.
REQ-023 SHALL, WAIT with edge detected at cycle M and index=4: at M+1 pulse frm_done, enter IDLE; earliest next gnt is M+2.
REQ-024 SHALL ignore req0/req1 and changes of cmd/data inputs outside IDLE; frame content comes only from latched values.
REQ-025 SHALL assert trmt exactly once per byte, never two consecutive cycles, never in IDLE.
REQ-026 SHALL drive no gnt when a request drops before being sampled in IDLE; no frame is sent.
REQ-027 SHALL never assert gnt0 and gnt1 in the same cycle.
REQ-028 SHALL hold WAIT indefinitely when tx_done never rises (no timeout).

Reset
REQ-029 SHALL, with rst high at a clock edge, set state=IDLE, index=0, gnt0=gnt1=0, trmt=0, frm_done=0, busy=0, tx_data=8'h00, tx_done edge register=0, round-robin pointer to favour port 0.
REQ-030 SHALL abandon any frame in progress when rst asserts mid-frame; no frm_done for the aborted frame.
REQ-031 SHALL accept a new request in the first cycle after rst deasserts (gnt one cycle later).

Verification
REQ-032 SHALL cover: req0=1, cmd0=8'h02, data0=16'h1234, UART model -> bytes A5,02,12,34,B7; one gnt0; one frm_done.
REQ-033 SHALL cover: req0 and req1 asserted together, held -> port 0 frame, then port 1 frame, then port 0 frame (alternation).
REQ-034 SHALL cover: tx_done held high from the prior byte through trmt+1 -> no byte advance until tx_done falls and rises again.
REQ-035 SHALL cover: cmd0/data0 changed during a frame -> transmitted bytes and chk match values latched at gnt0.
REQ-036 SHALL cover: rst during byte 3 -> next cycle trmt=0, busy=0, no frm_done; a following request sends a complete fresh frame starting with A5.
REQ-037 SHALL cover: cmd=8'hFF, data=16'hFFFF -> chk = ~(8'hFD) = 8'h02 (sum wraps modulo 256).
